// File: rtl/fsm_progress_monitor.sv
// fsm_progress_monitor
// Watches the 13-step detector FSM's step code, decodes it to a step index,
// polices every step transition and reports completion, aborts, illegal
// jumps, unrecognised codes and stalls. All outputs are registered, so each
// sampled code is reflected one cycle later.
module fsm_progress_monitor #(
    parameter int CODE_W  = 17,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CODE_W-1:0] code,
    output logic [3:0]        step,
    output logic              valid_code,
    output logic              done,
    output logic              abort,
    output logic              error,
    output logic              timeout,
    output logic [CNT_W-1:0]  abort_count,
    output logic [3:0]        best_step
);

    // Monitor states
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TRACK = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam logic [3:0] LAST_STEP = 4'd12;

    // dwell counts repeats of the current step and never needs to exceed TIMEOUT
    localparam int DW_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [DW_W-1:0] DWELL_LIMIT = DW_W'(TIMEOUT);

    logic [1:0]      state;
    logic [DW_W-1:0] dwell;

    // Decoded sample
    logic [3:0] n_idx;
    logic       n_ok;

    // Next-state values
    logic [1:0]      state_nx;
    logic [DW_W-1:0] dwell_nx;
    logic [3:0]      step_nx;
    logic            done_nx;
    logic            abort_nx;
    logic            error_nx;
    logic            timeout_nx;
    logic            count_inc;

    logic [DW_W-1:0] dwell_inc;
    logic [3:0]      step_inc;

    assign dwell_inc = dwell + 1'b1;
    assign step_inc  = step + 4'd1;

    // Map the detector's step code to an index; anything off the table is invalid
    always_comb begin
        n_idx = 4'd0;
        n_ok  = 1'b1;
        case (code)
            CODE_W'(0):    n_idx = 4'd0;
            CODE_W'(200):  n_idx = 4'd1;
            CODE_W'(700):  n_idx = 4'd2;
            CODE_W'(900):  n_idx = 4'd3;
            CODE_W'(1300): n_idx = 4'd4;
            CODE_W'(1800): n_idx = 4'd5;
            CODE_W'(2300): n_idx = 4'd6;
            CODE_W'(2800): n_idx = 4'd7;
            CODE_W'(3100): n_idx = 4'd8;
            CODE_W'(3400): n_idx = 4'd9;
            CODE_W'(3600): n_idx = 4'd10;
            CODE_W'(3800): n_idx = 4'd11;
            CODE_W'(4100): n_idx = 4'd12;
            default: begin
                n_idx = 4'd0;
                n_ok  = 1'b0;
            end
        endcase
    end

    // Transition rules: invalid code first, then legal moves, then the stall check
    always_comb begin
        state_nx   = state;
        dwell_nx   = dwell;
        step_nx    = step;
        done_nx    = 1'b0;
        abort_nx   = 1'b0;
        error_nx   = 1'b0;
        timeout_nx = 1'b0;
        count_inc  = 1'b0;

        if (!n_ok) begin
            // step holds on an unrecognised code; only the first one reports
            if (state != S_FAULT) begin
                error_nx = 1'b1;
                state_nx = S_FAULT;
            end
        end else begin
            step_nx = n_idx;
            case (state)
                S_IDLE: begin
                    if (n_idx == 4'd1) begin
                        state_nx = S_TRACK;
                        dwell_nx = '0;
                    end else if (n_idx != 4'd0) begin
                        error_nx = 1'b1;
                        state_nx = S_FAULT;
                    end
                end

                S_TRACK: begin
                    if (n_idx == step_inc) begin
                        // an advance always wins over a stall on the same edge
                        dwell_nx = '0;
                        if (n_idx == LAST_STEP) begin
                            done_nx  = 1'b1;
                            state_nx = S_DONE;
                        end
                    end else if (n_idx == step) begin
                        if (dwell_inc >= DWELL_LIMIT) begin
                            timeout_nx = 1'b1;
                            error_nx   = 1'b1;
                            state_nx   = S_FAULT;
                            dwell_nx   = '0;
                        end else begin
                            dwell_nx = dwell_inc;
                        end
                    end else if (n_idx == 4'd0) begin
                        abort_nx  = 1'b1;
                        count_inc = 1'b1;
                        state_nx  = S_IDLE;
                        dwell_nx  = '0;
                    end else begin
                        error_nx = 1'b1;
                        state_nx = S_FAULT;
                        dwell_nx = '0;
                    end
                end

                S_DONE: begin
                    if (n_idx == 4'd0) begin
                        state_nx = S_IDLE;
                    end else if (n_idx != LAST_STEP) begin
                        error_nx = 1'b1;
                        state_nx = S_FAULT;
                    end
                end

                default: begin
                    // FAULT: follow the code silently until the detector returns to 0
                    if (n_idx == 4'd0) begin
                        state_nx = S_IDLE;
                    end
                end
            endcase
        end
    end

    // State, dwell and the decoded step
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            dwell <= '0;
            step  <= 4'd0;
        end else begin
            state <= state_nx;
            dwell <= dwell_nx;
            step  <= step_nx;
        end
    end

    // One-cycle status pulses and the code-valid flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_code <= 1'b1;
            done       <= 1'b0;
            abort      <= 1'b0;
            error      <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            valid_code <= n_ok;
            done       <= done_nx;
            abort      <= abort_nx;
            error      <= error_nx;
            timeout    <= timeout_nx;
        end
    end

    // Saturating abort counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            abort_count <= '0;
        end else if (count_inc && (abort_count != {CNT_W{1'b1}})) begin
            abort_count <= abort_count + 1'b1;
        end
    end

    // High-water mark of valid step indices, tracked in every state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            best_step <= 4'd0;
        end else if (n_ok && (n_idx > best_step)) begin
            best_step <= n_idx;
        end
    end

endmodule

// File: tb/tb_fsm_progress_monitor.sv
// tb_fsm_progress_monitor
// Directed stimulus against fsm_progress_monitor (TIMEOUT=4). A rule-level
// model predicts every output and is compared each negative clock edge;
// literal expectations at key points pin the model to hand-computed values.
module tb_fsm_progress_monitor;

    localparam int CODE_W = 17;
    localparam int TO     = 4;
    localparam int CNT_W  = 8;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [CODE_W-1:0] code = '0;
    logic [3:0]        step;
    logic              valid_code, done, abort, error, timeout;
    logic [CNT_W-1:0]  abort_count;
    logic [3:0]        best_step;

    int checks = 0;
    int errors = 0;

    fsm_progress_monitor #(.CODE_W(CODE_W), .TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .code(code), .step(step),
        .valid_code(valid_code), .done(done), .abort(abort), .error(error),
        .timeout(timeout), .abort_count(abort_count), .best_step(best_step)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_TRACK, M_DONE, M_FAULT} mode_t;

    int    step_codes[13] = '{0, 200, 700, 900, 1300, 1800, 2300, 2800, 3100, 3400, 3600, 3800, 4100};
    mode_t m_mode  = M_IDLE;
    int    m_run   = 0;   // samples seen of the current step while tracking
    int    m_step  = 0;
    int    m_valid = 1;
    int    m_done  = 0;
    int    m_abort = 0;
    int    m_err   = 0;
    int    m_to    = 0;
    int    m_cnt   = 0;
    int    m_best  = 0;

    function automatic int index_of(input int c);
        for (int i = 0; i < 13; i++)
            if (step_codes[i] == c) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_run = 0; m_step = 0; m_valid = 1;
        m_done = 0; m_abort = 0; m_err = 0; m_to = 0; m_cnt = 0; m_best = 0;
    endtask

    task automatic go_fault();
        m_err  = 1;
        m_mode = M_FAULT;
    endtask

    task automatic model_sample(input int c);
        int n, prev;
        n = index_of(c);
        m_done = 0; m_abort = 0; m_err = 0; m_to = 0;
        if (n < 0) begin
            m_valid = 0;
            if (m_mode != M_FAULT) go_fault();
        end else begin
            m_valid = 1;
            prev    = m_step;
            m_step  = n;
            if (n > m_best) m_best = n;
            case (m_mode)
                M_IDLE:
                    if (n == 1) begin m_mode = M_TRACK; m_run = 1; end
                    else if (n != 0) go_fault();
                M_TRACK:
                    if (n == prev + 1) begin
                        m_run = 1;
                        if (n == 12) begin m_done = 1; m_mode = M_DONE; end
                    end else if (n == prev) begin
                        m_run++;
                        if (m_run == TO + 1) begin m_to = 1; go_fault(); end
                    end else if (n == 0) begin
                        m_abort = 1;
                        m_cnt   = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
                        m_mode  = M_IDLE;
                    end else go_fault();
                M_DONE:
                    if (n == 0) m_mode = M_IDLE;
                    else if (n != 12) go_fault();
                default:
                    if (n == 0) m_mode = M_IDLE;
            endcase
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_sample(int'(code));
        end
    end

    // ---------------- checking ----------------
    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cmp("model step",        32'(step),        32'(m_step));
            cmp("model valid_code",  32'(valid_code),  32'(m_valid));
            cmp("model done",        32'(done),        32'(m_done));
            cmp("model abort",       32'(abort),       32'(m_abort));
            cmp("model error",       32'(error),       32'(m_err));
            cmp("model timeout",     32'(timeout),     32'(m_to));
            cmp("model abort_count", 32'(abort_count), 32'(m_cnt));
            cmp("model best_step",   32'(best_step),   32'(m_best));
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply(input int c);
        @(negedge clk);
        code = CODE_W'(c);
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input int s[$]);
        foreach (s[i]) apply(s[i]);
    endtask

    task automatic check_reset_values(input string tag);
        cmp({tag, " step"},        32'(step),        0);
        cmp({tag, " valid_code"},  32'(valid_code),  1);
        cmp({tag, " done"},        32'(done),        0);
        cmp({tag, " abort"},       32'(abort),       0);
        cmp({tag, " error"},       32'(error),       0);
        cmp({tag, " timeout"},     32'(timeout),     0);
        cmp({tag, " abort_count"}, 32'(abort_count), 0);
        cmp({tag, " best_step"},   32'(best_step),   0);
    endtask

    // Reset asserted between clock edges; outputs must clear before the next edge
    task automatic do_reset(input string tag);
        @(negedge clk);
        code = '0;
        #2 reset = 1'b1;
        #1 check_reset_values(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int q[$];

        #1 reset = 1'b1;
        #2 check_reset_values("por");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Full legal walk 0..12
        for (int i = 0; i < 13; i++) begin
            apply(step_codes[i]);
            cmp("walk step", 32'(step), 32'(i));
        end
        cmp("walk done", 32'(done), 1);
        cmp("walk best", 32'(best_step), 12);
        apply(4100);
        cmp("done hold no pulse", 32'(done), 0);
        cmp("done hold step", 32'(step), 12);
        apply(0);
        cmp("done exit no abort", 32'(abort), 0);

        // Abort from step 2
        do_reset("rst abort");
        q = '{0, 200, 700, 0};
        run_seq(q);
        cmp("abort pulse", 32'(abort), 1);
        cmp("abort count", 32'(abort_count), 1);
        cmp("abort best", 32'(best_step), 2);
        apply(0);
        cmp("abort single pulse", 32'(abort), 0);
        apply(200);
        cmp("after abort idle->track", 32'(error), 0);

        // Illegal jump, then silence in FAULT, then recovery
        do_reset("rst jump");
        q = '{0, 200, 1300};
        run_seq(q);
        cmp("jump error", 32'(error), 1);
        apply(1300);
        cmp("jump no second error", 32'(error), 0);
        apply(777);
        cmp("fault invalid valid_code", 32'(valid_code), 0);
        cmp("fault invalid no error", 32'(error), 0);
        apply(0);
        cmp("jump recover step", 32'(step), 0);
        apply(200);
        cmp("jump recover idle", 32'(error), 0);

        // Invalid code while at step 3
        do_reset("rst invalid");
        q = '{0, 200, 700, 900, 500};
        run_seq(q);
        cmp("invalid valid_code", 32'(valid_code), 0);
        cmp("invalid step hold", 32'(step), 3);
        cmp("invalid error", 32'(error), 1);
        apply(0);
        cmp("invalid one cycle", 32'(valid_code), 1);

        // Stall: 1800 sampled TO+1 times
        do_reset("rst stall");
        q = '{0, 200, 700, 900, 1300, 1800, 1800, 1800, 1800};
        run_seq(q);
        cmp("stall early", 32'(timeout), 0);
        apply(1800);
        cmp("stall timeout", 32'(timeout), 1);
        cmp("stall error", 32'(error), 1);
        apply(0);
        // Advance on the sample that would otherwise stall
        q = '{0, 200, 700, 900, 1300, 1800, 1800, 1800, 1800, 2300};
        run_seq(q);
        cmp("advance step", 32'(step), 6);
        cmp("advance no timeout", 32'(timeout), 0);
        cmp("advance no error", 32'(error), 0);

        // Abort counter saturation
        do_reset("rst sat");
        apply(0);
        for (int i = 0; i < 300; i++) begin
            apply(200);
            apply(0);
        end
        cmp("abort saturate", 32'(abort_count), 255);

        // Asynchronous reset mid-sequence at step 7
        q = '{0, 200, 700, 900, 1300, 1800, 2300, 2800};
        run_seq(q);
        cmp("pre reset step", 32'(step), 7);
        do_reset("rst mid");
        apply(200);
        cmp("post reset first edge idle", 32'(step), 1);
        apply(0);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsm_progress_monitor.md
# fsm_progress_monitor

Downstream consumer of the 13-step sequence-detector FSM. Samples the detector's 17-bit step code every clock, decodes it to a step index, checks that every step change is legal, and reports completion, aborts, illegal jumps, invalid codes and stalls. Its flags and counters feed the status/debug logic that sits after the detector.

## Interface
Parameters:
- CODE_W, 17, width of the incoming step code.
- TIMEOUT, 16, repeated samples of one step (steps 1..11) before a stall is flagged; must be ≥1.
- CNT_W, 8, width of the abort counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- code  input  CODE_W  step code from the detector FSM.
- step  output  4  registered decoded step index, 0..12.
- valid_code  output  1  low for one cycle after an unrecognised code is sampled.
- done  output  1  one-cycle pulse when step 12 is reached from step 11.
- abort  output  1  one-cycle pulse on return to step 0 from steps 1..11.
- error  output  1  one-cycle pulse on entry to FAULT.
- timeout  output  1  one-cycle pulse on a stall.
- abort_count  output  CNT_W  saturating count of aborts.
- best_step  output  4  highest step reached since reset.

## Operation
- Decode map (code → index): 0→0, 200→1, 700→2, 900→3, 1300→4, 1800→5, 2300→6, 2800→7, 3100→8, 3400→9, 3600→10, 3800→11, 4100→12. Any other value is invalid.
- Monitor states are IDLE, TRACK, DONE and FAULT. At each edge, n is the decoded index of the sampled code and step holds the previous index.
- IDLE: n=0 stays in IDLE. n=1 goes to TRACK. Any other valid n pulses error and goes to FAULT.
- TRACK: n=step holds and increments dwell. n=step+1 advances and clears dwell; if n=12, done pulses and the state goes to DONE. n=0 pulses abort, increments abort_count and goes to IDLE. Any other n pulses error and goes to FAULT.
- DONE: n=12 holds. n=0 goes to IDLE with no abort. Any other n pulses error and goes to FAULT.
- FAULT: step tracks n and no further error pulses are generated. n=0 goes to IDLE.
- Invalid code in any state other than FAULT: valid_code=0, step holds, error pulses, state goes to FAULT.
- Invalid code in FAULT: valid_code=0 and step holds, with no error pulse.
- Stall: in TRACK, when dwell reaches TIMEOUT, timeout and error both pulse and the state goes to FAULT. dwell counts repeats only, so the stall fires on the (TIMEOUT+1)-th consecutive sample of the same step.
- best_step updates to n whenever n>best_step and n is valid, in any state.
- abort_count saturates at 2^CNT_W−1.

## Timing
- All outputs are registered. A code sampled at edge k is reflected on step, valid_code and the pulses immediately after edge k, so latency is one cycle.
- Pulses are exactly one cycle wide and are never asserted in back-to-back cycles by the same event.
- Simultaneous conditions, in priority order: invalid code > legal advance > stall. A legal advance at the same edge where dwell would hit TIMEOUT is an advance with no timeout.
- Step 0 never times out, and DONE never times out.
- Asynchronous reset takes effect immediately, including mid-sequence. Reset values: step=0, valid_code=1, done=abort=error=timeout=0, abort_count=0, best_step=0, state=IDLE, dwell=0.
- The first edge after reset deasserts is treated as an IDLE-state sample.

## Test plan
- Codes 0,200,700,900,1300,1800,2300,2800,3100,3400,3600,3800,4100, one per cycle → step counts 0..12; done high only in the cycle after 4100 is sampled; best_step=12; error, abort and timeout never assert.
- Codes 0,200,700,0 → abort pulses once after 0 is sampled; abort_count=1; state IDLE; best_step=2.
- Codes 0,200,1300,1300,0 → error pulses once after the first 1300; no second pulse; after the final 0 the monitor is in IDLE and step=0.
- Code 500 while at step 3 → valid_code=0 for one cycle, step stays 3, error pulses, state FAULT.
- With TIMEOUT=4, code 1800 held for 5 samples → timeout and error pulse after the 5th sample. Repeat with 2300 applied on the 5th sample instead → an advance to step 6 with no timeout.
- Drive 300 aborts with CNT_W=8 → abort_count saturates at 255. Assert reset mid-sequence at step 7 → all outputs return to reset values immediately, without waiting for a clock edge.
